// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: adds WIDTH-bit operands DIGIT bits per clock, LSB digit first,
// with a registered carry between digits and a start/busy/done handshake.
module digit_serial_addsub #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NDIG = (DIGIT < 1) ? 1 : WIDTH / DIGIT;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int MSB  = WIDTH - 1;

  generate
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("digit_serial_addsub: DIGIT must be >= 1 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [KW-1:0]    k;
  logic             accept;
  logic             last;
  int unsigned      base;
  logic [DIGIT-1:0] da;
  logic [DIGIT-1:0] db;
  logic [DIGIT-1:0] dsum;
  logic             dcarry;
  logic [WIDTH-1:0] sum_merged;

  // A start is only honoured outside RUN, which covers the back-to-back case in DONE.
  assign accept = start && (state != RUN);
  assign last   = (k == KW'(NDIG - 1));

  // NOTE: every always_comb output gets a default before any conditional update; a path that
  // leaves a variable unassigned would infer a latch.
  always_comb begin
    base       = int'(k) * DIGIT;
    da         = a_reg[base +: DIGIT];
    db         = b_reg[base +: DIGIT];
    {dcarry, dsum} = {1'b0, da} + {1'b0, db} + {{DIGIT{1'b0}}, carry};
    sum_merged = sum;
    sum_merged[base +: DIGIT] = dsum;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Operands are stored pre-conditioned (b inverted, carry forced) so RUN is a plain add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      k     <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      k     <= '0;
      sum   <= '0;
    end else if (state == RUN) begin
      sum   <= sum_merged;
      carry <= dcarry;
      k     <= last ? '0 : k + KW'(1);
      if (last) begin
        cout <= dcarry;
        ovf  <= (a_reg[MSB] == b_reg[MSB]) && (sum_merged[MSB] != a_reg[MSB]);
        zero <= (sum_merged == '0);
      end
    end
  end

endmodule
